instr_exec_unit: RTL and testbench

//  Execution stage directly downstream of the ROM instruction sequencer.
//  - Consumes the 8-bit instruction stream and the sequencer's done flag.
//  - Decodes each instruction and executes it on an accumulator.
//  - Reports the result, zero/carry flags, a retired-instruction count and halt/finish status.
//  - Multi-cycle MUL support; ready/valid handshake back-pressures the fetch side.

---
 rtl/instr_exec_unit_if.sv | 23 ++
 rtl/instr_exec_unit.sv | 169 ++++++++++++++++
 tb/tb_instr_exec_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_exec_unit_if.sv
// Fetch-side handshake between the ROM instruction sequencer and the execution unit.
interface instr_exec_unit_if;
    logic [7:0] instr_in;
    logic       instr_valid;
    logic       instr_ready;
    logic       seq_done;

    // Sequencer side: drives instructions and the done level.
    modport master (
        output instr_in,
        output instr_valid,
        output seq_done,
        input  instr_ready
    );

    // Execution-unit side: consumes instructions, back-pressures with ready.
    modport slave (
        input  instr_in,
        input  instr_valid,
        input  seq_done,
        output instr_ready
    );
endinterface

// File: rtl/instr_exec_unit.sv
// Accumulator execution stage: decodes 8-bit instructions, runs a 5-step
// shift-add multiply, and reports flags, retire count and halt/finish status.
module instr_exec_unit #(
    parameter int unsigned ACC_W     = 8,
    parameter bit          SAT_ARITH = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_exec_unit_if.slave     fetch,
    output logic [ACC_W-1:0]     acc_out,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 retire_pulse,
    output logic [7:0]           retire_cnt,
    output logic                 halted,
    output logic                 exec_done
);

    localparam int unsigned IMM_W  = 5;
    localparam int unsigned PROD_W = ACC_W + IMM_W;

    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_HALT,
        S_FIN
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          ir_q, ir_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                z_q, z_d;
    logic                c_q, c_d;
    logic                pulse_q, pulse_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                halted_q, halted_d;
    logic                done_q, done_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [2:0]          mbit_q, mbit_d;

    logic                accept;
    logic [ACC_W-1:0]    imm_ext;
    logic [ACC_W:0]      sum;
    logic [ACC_W:0]      diff;
    logic [ACC_W-1:0]    add_res;
    logic [ACC_W-1:0]    sub_res;
    logic [ACC_W-1:0]    and_res;
    logic [ACC_W-1:0]    xor_res;
    logic [PROD_W-1:0]   mul_step;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        acc_d    = acc_q;
        z_d      = z_q;
        c_d      = c_q;
        pulse_d  = 1'b0;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mbit_d   = mbit_q;

        accept   = (state_q == S_IDLE) && ready_q && fetch.instr_valid;
        imm_ext  = ACC_W'(ir_q[4:0]);
        sum      = {1'b0, acc_q} + {1'b0, imm_ext};
        diff     = {1'b0, acc_q} - {1'b0, imm_ext};
        add_res  = (SAT_ARITH && sum[ACC_W])  ? '1 : sum[ACC_W-1:0];
        sub_res  = (SAT_ARITH && diff[ACC_W]) ? '0 : diff[ACC_W-1:0];
        and_res  = acc_q & imm_ext;
        xor_res  = acc_q ^ imm_ext;
        mul_step = prod_q + (ir_q[mbit_q] ? (PROD_W'(acc_q) << mbit_q) : PROD_W'(0));

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ir_d    = fetch.instr_in;
                    prod_d  = '0;
                    mbit_d  = 3'd0;
                    state_d = (fetch.instr_in[7:5] == OP_MUL) ? S_MUL : S_EXEC;
                end else if (fetch.seq_done) begin
                    state_d = S_FIN;
                end
            end
            S_EXEC: begin
                pulse_d = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                state_d = S_IDLE;
                case (ir_q[7:5])
                    OP_LDI: begin acc_d = imm_ext; c_d = 1'b0;      z_d = (imm_ext == '0); end
                    OP_ADD: begin acc_d = add_res; c_d = sum[ACC_W];  z_d = (add_res == '0); end
                    OP_SUB: begin acc_d = sub_res; c_d = diff[ACC_W]; z_d = (sub_res == '0); end
                    OP_AND: begin acc_d = and_res; c_d = 1'b0;      z_d = (and_res == '0); end
                    OP_XOR: begin acc_d = xor_res; c_d = 1'b0;      z_d = (xor_res == '0); end
                    OP_HALT: state_d = S_HALT;
                    // NOP, and MUL whose result already committed in S_MUL
                    default: ;
                endcase
            end
            S_MUL: begin
                prod_d = mul_step;
                mbit_d = mbit_q + 3'd1;
                if (mbit_q == 3'd4) begin
                    acc_d   = mul_step[ACC_W-1:0];
                    c_d     = |mul_step[PROD_W-1:ACC_W];
                    z_d     = (mul_step[ACC_W-1:0] == '0);
                    state_d = S_EXEC;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_FIN:   state_d = S_FIN;
            default: state_d = S_IDLE;
        endcase

        ready_d  = (state_d == S_IDLE);
        halted_d = (state_d == S_HALT);
        done_d   = (state_d == S_FIN);
    end

    // State and output registers; async active-low reset aborts any multiply.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ir_q     <= '0;
            acc_q    <= '0;
            z_q      <= 1'b1;
            c_q      <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            halted_q <= 1'b0;
            done_q   <= 1'b0;
            prod_q   <= '0;
            mbit_q   <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            acc_q    <= acc_d;
            z_q      <= z_d;
            c_q      <= c_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            halted_q <= halted_d;
            done_q   <= done_d;
            prod_q   <= prod_d;
            mbit_q   <= mbit_d;
        end
    end

    assign fetch.instr_ready = ready_q;
    assign acc_out           = acc_q;
    assign flag_z            = z_q;
    assign flag_c            = c_q;
    assign retire_pulse      = pulse_q;
    assign retire_cnt        = cnt_q;
    assign halted            = halted_q;
    assign exec_done         = done_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed bench for instr_exec_unit: a wrapping instance and a saturating instance
// share the same stimulus; the saturating one is checked only where it differs.
module tb_instr_exec_unit;

    logic       clk;
    logic       rst;
    int         total = 0;
    int         bad   = 0;
    int         exp_cnt = 0;
    int         n;

    instr_exec_unit_if bus ();
    instr_exec_unit_if bus_s ();

    logic [7:0] acc, acc_s, rcnt, rcnt_s;
    logic       z, c, pulse, halted, done;
    logic       z_s, c_s, pulse_s, halted_s, done_s;

    instr_exec_unit #(.ACC_W(8), .SAT_ARITH(1'b0)) dut (
        .clk(clk), .rst(rst), .fetch(bus),
        .acc_out(acc), .flag_z(z), .flag_c(c), .retire_pulse(pulse),
        .retire_cnt(rcnt), .halted(halted), .exec_done(done)
    );

    instr_exec_unit #(.ACC_W(8), .SAT_ARITH(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .fetch(bus_s),
        .acc_out(acc_s), .flag_z(z_s), .flag_c(c_s), .retire_pulse(pulse_s),
        .retire_cnt(rcnt_s), .halted(halted_s), .exec_done(done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] ins, input logic sd);
        bus.instr_valid   = v;
        bus.instr_in      = ins;
        bus.seq_done      = sd;
        bus_s.instr_valid = v;
        bus_s.instr_in    = ins;
        bus_s.seq_done    = sd;
    endtask

    // Wait (bounded) for ready, present one instruction for a single accept edge.
    task automatic send(input logic [7:0] ins);
        int w = 0;
        while (bus.instr_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("ready_wait", 32'(bus.instr_ready), 32'd1);
        drive(1'b1, ins, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        exp_cnt++;
    endtask

    // Single-cycle op: accept, then the commit edge.
    task automatic exec1(input logic [7:0] ins);
        send(ins);
        tick();
    endtask

    task automatic check_acc(input string tag, input logic [7:0] ea, input logic ez, input logic ec);
        chk({tag, ".acc"}, 32'(acc), 32'(ea));
        chk({tag, ".z"},   32'(z),   32'(ez));
        chk({tag, ".c"},   32'(c),   32'(ec));
        chk({tag, ".cnt"}, 32'(rcnt), 32'(exp_cnt[7:0]));
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        exp_cnt = 0;
        tick();
        chk("rst.ready_after_release", 32'(bus.instr_ready), 32'd1);
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        // reset values while held
        chk("rst.acc",    32'(acc),    32'd0);
        chk("rst.z",      32'(z),      32'd1);
        chk("rst.c",      32'(c),      32'd0);
        chk("rst.cnt",    32'(rcnt),   32'd0);
        chk("rst.ready",  32'(bus.instr_ready), 32'd0);
        chk("rst.pulse",  32'(pulse),  32'd0);
        chk("rst.halted", 32'(halted), 32'd0);
        chk("rst.done",   32'(done),   32'd0);
        rst = 1'b1;
        tick();
        chk("rel.ready", 32'(bus.instr_ready), 32'd1);

        // LDI 5, ADD 3 with retire timing
        send(8'h25);
        chk("t1.ready_low", 32'(bus.instr_ready), 32'd0);
        chk("t1.pulse_early", 32'(pulse), 32'd0);
        tick();
        chk("t1.pulse_ldi", 32'(pulse), 32'd1);
        check_acc("t1.ldi", 8'h05, 1'b0, 1'b0);
        exec1(8'h43);
        chk("t1.pulse_add", 32'(pulse), 32'd1);
        check_acc("t1.add", 8'h08, 1'b0, 1'b0);
        tick();
        chk("t1.pulse_one_cycle", 32'(pulse), 32'd0);

        // LDI 31 then ADD 31 eight times: 279 wraps to 0x17, saturates to 0xFF
        exec1(8'h3F);
        for (int i = 1; i <= 8; i++) begin
            exec1(8'h5F);
            if (i == 7) check_acc("t2.add7", 8'hF8, 1'b0, 1'b0);
        end
        check_acc("t2.add8", 8'h17, 1'b0, 1'b1);
        chk("t2.sat.acc", 32'(acc_s), 32'hFF);
        chk("t2.sat.c",   32'(c_s),   32'd1);

        // LDI 0, SUB 1 borrow; NOP keeps flags; AND 0; XOR
        exec1(8'h20);
        check_acc("t3.ldi0", 8'h00, 1'b1, 1'b0);
        exec1(8'h61);
        check_acc("t3.sub", 8'hFF, 1'b0, 1'b1);
        chk("t3.sat.acc", 32'(acc_s), 32'h00);
        chk("t3.sat.c",   32'(c_s),   32'd1);
        chk("t3.sat.z",   32'(z_s),   32'd1);
        exec1(8'h00);
        check_acc("t3.nop", 8'hFF, 1'b0, 1'b1);
        exec1(8'h80);
        check_acc("t3.and", 8'h00, 1'b1, 1'b0);
        exec1(8'h25);
        exec1(8'hA3);
        check_acc("t3.xor", 8'h06, 1'b0, 1'b0);

        // LDI 20, MUL 13 -> 260 mod 256, ready low six cycles
        exec1(8'h34);
        send(8'hCD);
        n = 0;
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("t4.ready_low_cycles", 32'(n), 32'd6);
        chk("t4.pulse", 32'(pulse), 32'd1);
        check_acc("t4.mul", 8'h04, 1'b0, 1'b1);
        send(8'hC0);
        for (int i = 0; i < 6; i++) tick();
        check_acc("t4.mul0", 8'h00, 1'b1, 1'b0);

        // HALT is retired; later valid instruction ignored
        exec1(8'h2A);
        send(8'hE0);
        tick();
        chk("t5.halted", 32'(halted), 32'd1);
        chk("t5.pulse",  32'(pulse),  32'd1);
        check_acc("t5.halt", 8'h0A, 1'b0, 1'b0);
        drive(1'b1, 8'h27, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check_acc("t5.after_halt", 8'h0A, 1'b0, 1'b0);
        chk("t5.ready", 32'(bus.instr_ready), 32'd0);
        chk("t5.done_in_halt", 32'(done), 32'd0);
        chk("t5.still_halted", 32'(halted), 32'd1);

        // seq_done while IDLE -> FIN next cycle; later valid ignored
        do_reset();
        drive(1'b0, 8'h00, 1'b1);
        tick();
        chk("t5.fin.done",  32'(done), 32'd1);
        chk("t5.fin.ready", 32'(bus.instr_ready), 32'd0);
        drive(1'b1, 8'h29, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        check_acc("t5.fin.ignore", 8'h00, 1'b1, 1'b0);
        chk("t5.fin.pulse", 32'(pulse), 32'd0);

        // seq_done together with valid: accept first, finish after return to IDLE
        do_reset();
        drive(1'b1, 8'h29, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        exp_cnt++;
        chk("t5.both.done0", 32'(done), 32'd0);
        tick();
        check_acc("t5.both.ldi", 8'h09, 1'b0, 1'b0);
        chk("t5.both.done1", 32'(done), 32'd0);
        tick();
        chk("t5.both.done2", 32'(done), 32'd1);

        // reset asserted in the 3rd MUL cycle
        do_reset();
        exec1(8'h34);
        send(8'hCD);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        check_acc("t6.async", 8'h00, 1'b1, 1'b0);
        chk("t6.ready", 32'(bus.instr_ready), 32'd0);
        chk("t6.pulse", 32'(pulse), 32'd0);
        tick();
        tick();
        chk("t6.pulse_held", 32'(pulse), 32'd0);
        rst = 1'b1;
        tick();
        chk("t6.ready_release", 32'(bus.instr_ready), 32'd1);
        chk("t6.pulse_release", 32'(pulse), 32'd0);
        check_acc("t6.after", 8'h00, 1'b1, 1'b0);
        tick();
        chk("t6.no_late_pulse", 32'(pulse), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
